mem_arbiter: RTL and testbench

Arbitrates the single main-memory port between the instruction-cache and data-cache line transfers of the Abejaruco core. Each requester raises a request and holds it until a one-cycle done pulse. The arbiter serialises transfers, drives the memory port, and returns read lines. Its busy indication feeds the pipeline stall logic, so a fetch miss and a load/store miss never collide on memory.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared encodings and constants for the main-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Cache lines are 16 bytes; the low address bits never reach memory.
    localparam int c_LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Serialises icache/dcache line transfers onto one memory port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_req,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic                  icache_done,
    output logic [LINE_WIDTH-1:0] icache_data,
    input  logic                  dcache_req,
    input  logic                  dcache_we,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic                  dcache_done,
    output logic [LINE_WIDTH-1:0] dcache_data,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK =
        {{(ADDR_WIDTH-c_LINE_OFFSET_BITS){1'b1}}, {c_LINE_OFFSET_BITS{1'b0}}};

    state_t                r_state,        w_state_next;
    grant_t                r_last_grant,   w_last_grant_next;
    logic                  r_mem_enable,   w_mem_enable_next;
    logic                  r_mem_we,       w_mem_we_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr,     w_mem_addr_next;
    logic [LINE_WIDTH-1:0] r_mem_wdata,    w_mem_wdata_next;
    logic                  r_icache_done,  w_icache_done_next;
    logic                  r_dcache_done,  w_dcache_done_next;
    logic [LINE_WIDTH-1:0] r_icache_data,  w_icache_data_next;
    logic [LINE_WIDTH-1:0] r_dcache_data,  w_dcache_data_next;
    logic                  r_busy,         w_busy_next;
    logic                  w_grant_i;
    logic                  w_grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= GRANT_I;
            r_mem_enable  <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_icache_done <= 1'b0;
            r_dcache_done <= 1'b0;
            r_icache_data <= '0;
            r_dcache_data <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last_grant  <= w_last_grant_next;
            r_mem_enable  <= w_mem_enable_next;
            r_mem_we      <= w_mem_we_next;
            r_mem_addr    <= w_mem_addr_next;
            r_mem_wdata   <= w_mem_wdata_next;
            r_icache_done <= w_icache_done_next;
            r_dcache_done <= w_dcache_done_next;
            r_icache_data <= w_icache_data_next;
            r_dcache_data <= w_dcache_data_next;
            r_busy        <= w_busy_next;
        end
    end

    // Next-state logic also computes the next value of every registered output.
    always_comb begin
        w_state_next       = r_state;
        w_last_grant_next  = r_last_grant;
        w_mem_enable_next  = r_mem_enable;
        w_mem_we_next      = r_mem_we;
        w_mem_addr_next    = r_mem_addr;
        w_mem_wdata_next   = r_mem_wdata;
        w_icache_done_next = 1'b0;
        w_dcache_done_next = 1'b0;
        w_icache_data_next = r_icache_data;
        w_dcache_data_next = r_dcache_data;
        w_grant_i          = 1'b0;
        w_grant_d          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // On a tie the side that was not served last wins.
                w_grant_d = dcache_req && (!icache_req || (r_last_grant == GRANT_I));
                w_grant_i = icache_req && !w_grant_d;
                if (w_grant_d) begin
                    w_state_next      = ST_BUSY_D;
                    w_last_grant_next = GRANT_D;
                    w_mem_enable_next = 1'b1;
                    w_mem_we_next     = dcache_we;
                    w_mem_addr_next   = dcache_addr & c_ALIGN_MASK;
                    w_mem_wdata_next  = dcache_wdata;
                end else if (w_grant_i) begin
                    w_state_next      = ST_BUSY_I;
                    w_last_grant_next = GRANT_I;
                    w_mem_enable_next = 1'b1;
                    w_mem_we_next     = 1'b0;
                    w_mem_addr_next   = icache_addr & c_ALIGN_MASK;
                end
            end
            ST_BUSY_I: begin
                if (mem_ready) begin
                    w_state_next       = ST_DONE;
                    w_mem_enable_next  = 1'b0;
                    w_mem_we_next      = 1'b0;
                    w_icache_done_next = 1'b1;
                    w_icache_data_next = mem_rdata;
                end
            end
            ST_BUSY_D: begin
                if (mem_ready) begin
                    w_state_next       = ST_DONE;
                    w_mem_enable_next  = 1'b0;
                    w_mem_we_next      = 1'b0;
                    w_dcache_done_next = 1'b1;
                    if (!r_mem_we) begin
                        w_dcache_data_next = mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    assign icache_done = r_icache_done;
    assign icache_data = r_icache_data;
    assign dcache_done = r_dcache_done;
    assign dcache_data = r_dcache_data;
    assign mem_enable  = r_mem_enable;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a latency-programmable memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } req_t;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           lat;
    } memop_t;

    typedef struct {
        bit           is_d;
        logic [127:0] data;
    } done_t;

    typedef struct {
        bit           is_d;
        bit           we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           lat;
        logic [31:0]  exp_addr;
        int           exp_cycles;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         icache_req;
    logic [31:0]  icache_addr;
    logic         icache_done;
    logic [127:0] icache_data;
    logic         dcache_req;
    logic         dcache_we;
    logic [31:0]  dcache_addr;
    logic [127:0] dcache_wdata;
    logic         dcache_done;
    logic [127:0] dcache_data;
    logic         mem_enable;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         busy;

    mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
        .clk(clk), .reset(reset),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_done(icache_done), .icache_data(icache_data),
        .dcache_req(dcache_req), .dcache_we(dcache_we), .dcache_addr(dcache_addr),
        .dcache_wdata(dcache_wdata), .dcache_done(dcache_done), .dcache_data(dcache_data),
        .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    req_t   iq[$];
    req_t   dq[$];
    memop_t mq[$];
    done_t  doneq[$];
    logic [127:0] model_i = '0;
    logic [127:0] model_d = '0;
    int i_raise_cyc = 0, d_raise_cyc = 0;
    int i_done_cyc = 0, d_done_cyc = 0;
    int last_start_cyc = 0;
    int busy_cnt = 0;
    int spur_req = 0, spur_served = 0;
    bit spur_in_done = 0;
    vec_t vecs[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue one transfer: requester stimulus, expected memory op and expected done.
    task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [127:0] wdata, input logic [127:0] rdata,
                         input int lat, input logic [31:0] exp_addr, input bit expect_done);
        req_t r; memop_t m; done_t d;
        r.we = we; r.addr = addr; r.wdata = wdata;
        if (is_d) dq.push_back(r); else iq.push_back(r);
        m.we = is_d && we; m.addr = exp_addr; m.wdata = wdata; m.rdata = rdata; m.lat = lat;
        mq.push_back(m);
        if (expect_done) begin
            d.is_d = is_d;
            if (is_d) begin
                if (!we) model_d = rdata;
                d.data = model_d;
            end else begin
                model_i = rdata;
                d.data = model_i;
            end
            doneq.push_back(d);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((busy || icache_req || dcache_req || iq.size() > 0 || dq.size() > 0 ||
                    mq.size() > 0 || doneq.size() > 0) && n < budget);
        chk("idle_timeout", n < budget, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_i = '0;
        model_d = '0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Instruction-side requester: holds req until done, then takes the next queued line.
    initial begin
        req_t r;
        icache_req = 1'b0; icache_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) icache_req = 1'b0;
            else begin
                if (icache_req && icache_done) icache_req = 1'b0;
                if (!icache_req && iq.size() > 0) begin
                    r = iq.pop_front();
                    icache_addr = r.addr; icache_req = 1'b1; i_raise_cyc = cyc;
                end
            end
        end
    end

    initial begin
        req_t r;
        dcache_req = 1'b0; dcache_we = 1'b0; dcache_addr = '0; dcache_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) dcache_req = 1'b0;
            else begin
                if (dcache_req && dcache_done) dcache_req = 1'b0;
                if (!dcache_req && dq.size() > 0) begin
                    r = dq.pop_front();
                    dcache_we = r.we; dcache_addr = r.addr; dcache_wdata = r.wdata;
                    dcache_req = 1'b1; d_raise_cyc = cyc;
                end
            end
        end
    end

    // Memory model: checks each operation against the scoreboard and answers after lat cycles.
    initial begin
        memop_t cur;
        bit active = 0;
        bit dspur = 0;
        int cnt = 0;
        mem_ready = 1'b0; mem_rdata = '0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (dspur) begin
                mem_ready = 1'b1; mem_rdata = {4{32'hBADC0FFE}}; dspur = 0;
            end else if (spur_req != spur_served && !mem_enable) begin
                mem_ready = 1'b1; mem_rdata = {4{32'hFEEDFACE}}; spur_served++;
            end
            if (mem_enable) begin
                if (!active) begin
                    last_start_cyc = cyc;
                    chk("mem_op_expected", mq.size() > 0, 1'b1);
                    if (mq.size() > 0) begin
                        cur = mq.pop_front(); active = 1; cnt = 0;
                    end
                end
                if (active) begin
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", mem_we, cur.we);
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                    cnt++;
                    if (cnt >= cur.lat) begin
                        mem_ready = 1'b1; mem_rdata = cur.rdata; active = 0;
                        if (spur_in_done) dspur = 1;
                    end
                end
            end else begin
                active = 0;
            end
        end
    end

    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (icache_done || dcache_done) begin
                chk("single_done", icache_done && dcache_done, 1'b0);
                if (icache_done) i_done_cyc = cyc;
                if (dcache_done) d_done_cyc = cyc;
                chk("done_expected", doneq.size() > 0, 1'b1);
                if (doneq.size() > 0) begin
                    e = doneq.pop_front();
                    chk("done_side", dcache_done, e.is_d);
                    chk("done_data", e.is_d ? dcache_data : icache_data, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        vecs[0] = '{0, 0, 32'h0000_0044, '0, {4{32'hDEADBEEF}}, 5, 32'h0000_0040, 6};
        vecs[1] = '{1, 0, 32'h0000_0208, '0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 3, 32'h0000_0200, 4};
        vecs[2] = '{1, 1, 32'h0000_0100, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, {4{32'h0BAD0BAD}}, 5, 32'h0000_0100, 6};
        vecs[3] = '{0, 0, 32'hFFFF_FFFF, '0, {4{32'hC001D00D}}, 1, 32'hFFFF_FFF0, 2};
        vecs[4] = '{1, 0, 32'h8000_000C, '0, {4{32'h5A5A_A5A5}}, 2, 32'h8000_0000, 3};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_enable", mem_enable, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_icache_done", icache_done, 1'b0);
        chk("rst_dcache_done", dcache_done, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_icache_data", icache_data, 128'h0);
        chk("rst_dcache_data", dcache_data, 128'h0);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            b0 = busy_cnt;
            issue(vecs[k].is_d, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].rdata,
                  vecs[k].lat, vecs[k].exp_addr, 1'b1);
            wait_idle(100);
            chk("busy_cycles", busy_cnt - b0, vecs[k].exp_cycles);
            if (vecs[k].is_d) chk("req_to_done_d", d_done_cyc - d_raise_cyc, vecs[k].exp_cycles);
            else              chk("req_to_done_i", i_done_cyc - i_raise_cyc, vecs[k].exp_cycles);
        end
        chk("icache_data_held", icache_data, model_i);
        chk("dcache_data_held", dcache_data, model_d);

        // Simultaneous requests straight after reset: data side first.
        do_reset();
        issue(1, 0, 32'h0000_0300, '0, {4{32'hAAAA_0300}}, 4, 32'h0000_0300, 1'b1);
        issue(0, 0, 32'h0000_0404, '0, {4{32'hBBBB_0400}}, 4, 32'h0000_0400, 1'b1);
        wait_idle(100);
        chk("b2b_busy_gap", last_start_cyc - d_done_cyc, 2);
        chk("b2b_i_done", i_done_cyc - d_done_cyc, 6);

        // Both sides re-request continuously: grants alternate D, I, D, I.
        do_reset();
        issue(1, 0, 32'h0000_1000, '0, {4{32'h1111_1000}}, 2, 32'h0000_1000, 1'b1);
        issue(0, 0, 32'h0000_2000, '0, {4{32'h2222_2000}}, 2, 32'h0000_2000, 1'b1);
        issue(1, 0, 32'h0000_3000, '0, {4{32'h3333_3000}}, 2, 32'h0000_3000, 1'b1);
        issue(0, 0, 32'h0000_4000, '0, {4{32'h4444_4000}}, 2, 32'h0000_4000, 1'b1);
        wait_idle(200);

        // Reset in the third BUSY cycle abandons the transfer.
        issue(1, 0, 32'h0000_0500, '0, {4{32'h5555_0500}}, 20, 32'h0000_0500, 1'b0);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!mem_enable && n < 20);
        chk("enable_timeout", n < 20, 1'b1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        model_i = '0; model_d = '0;
        #1;
        chk("midrst_mem_enable", mem_enable, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_dcache_data", dcache_data, 128'h0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        chk("midrst_stays_idle", {busy, mem_enable}, 2'b00);
        issue(0, 0, 32'h0000_0608, '0, {4{32'h6666_0600}}, 3, 32'h0000_0600, 1'b1);
        wait_idle(100);
        chk("after_rst_req_to_done", i_done_cyc - i_raise_cyc, 4);

        // Spurious mem_ready in IDLE and in DONE.
        spur_req++;
        repeat (4) @(negedge clk);
        #1;
        chk("spur_idle_busy", busy, 1'b0);
        chk("spur_idle_enable", mem_enable, 1'b0);
        chk("spur_idle_icache_data", icache_data, model_i);
        chk("spur_idle_dcache_data", dcache_data, model_d);
        chk("spur_served", spur_served, spur_req);
        spur_in_done = 1'b1;
        issue(1, 0, 32'h0000_0700, '0, {4{32'h7777_0700}}, 3, 32'h0000_0700, 1'b1);
        wait_idle(100);
        spur_in_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("spur_done_dcache_data", dcache_data, model_d);
        chk("spur_done_icache_data", icache_data, model_i);
        chk("spur_done_busy", busy, 1'b0);

        chk("queues_empty", mq.size() + doneq.size() + iq.size() + dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
